elevator_ctrl: RTL

Parametrised N-floor elevator controller: latches per-floor call requests, moves the car one floor per `MOVE_CYCLES` using a SCAN (continue-in-direction) policy, and holds the door open for `DOOR_CYCLES` at each served floor. It is the next-generation car controller in the FSM library, replacing fixed 4-floor up/down stepping with request queuing, direction memory and door timing. It is driven by a hall/car button aggregator and feeds floor display and motor/door drivers.

---
 rtl/elevator_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - SCAN elevator car controller with request latching and door timing
// Optional: define ELEVATOR_ESTOP_EN to add the estop hold input.
module elevator_ctrl #(
  parameter  int FLOORS      = 8,
  parameter  int MOVE_CYCLES = 3,
  parameter  int DOOR_CYCLES = 4,
  localparam int FW          = (FLOORS > 2) ? $clog2(FLOORS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] call_req,
`ifdef ELEVATOR_ESTOP_EN
  input  logic              estop,
`endif
  output logic [FW-1:0]     floor,
  output logic              moving_up,
  output logic              moving_down,
  output logic              door_open,
  output logic [FLOORS-1:0] pending
);

  localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR} state_t;

  state_t          state;
  logic            dir_up;
  logic [MW-1:0]   move_cnt;
  logic [DW-1:0]   door_cnt;

  logic              hold;
  logic [FLOORS-1:0] eff;
  logic [FLOORS-1:0] cur_bit;
  logic [FLOORS-1:0] clear;
  logic [FLOORS-1:0] pend_nxt;
  logic [FW-1:0]     floor_up;
  logic [FW-1:0]     floor_dn;
  logic              here_i, above_i, below_i;
  logic              cont_up, cont_dn;

  function automatic logic any_above(input logic [FLOORS-1:0] v, input int f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (i > f && v[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input int f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (i < f && v[i]) r = 1'b1;
    return r;
  endfunction

  // Request view, served-bit clearing and arrival look-ahead
  always_comb begin
`ifdef ELEVATOR_ESTOP_EN
    hold = estop;
`else
    hold = 1'b0;
`endif
    eff            = pending | call_req;
    cur_bit        = '0;
    cur_bit[floor] = 1'b1;
    clear          = '0;
    if (!hold) begin
      if (state == S_IDLE && eff[floor])      clear = cur_bit;
      if (state == S_DOOR && call_req[floor]) clear = cur_bit;
    end
    pend_nxt = eff & ~clear;
    here_i   = eff[floor];
    above_i  = any_above(eff, int'(floor));
    below_i  = any_below(eff, int'(floor));
    floor_up = floor + 1'b1;
    floor_dn = floor - 1'b1;
    // Keep travelling only when the next floor is not a stop and work remains beyond it;
    // a stop goes through IDLE, which opens the door one cycle after arrival.
    cont_up  = !pend_nxt[floor_up] && any_above(pend_nxt, int'(floor_up));
    cont_dn  = !pend_nxt[floor_dn] && any_below(pend_nxt, int'(floor_dn));
  end

  // Car FSM with registered status outputs; estop freezes everything except request latching
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      floor       <= '0;
      pending     <= '0;
      dir_up      <= 1'b1;
      move_cnt    <= '0;
      door_cnt    <= '0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (!hold) begin
        case (state)
          S_IDLE: begin
            if (here_i) begin
              state     <= S_DOOR;
              door_open <= 1'b1;
              door_cnt  <= '0;
            end else if (above_i && (dir_up || !below_i)) begin
              state     <= S_MOVE_UP;
              dir_up    <= 1'b1;
              moving_up <= 1'b1;
              move_cnt  <= '0;
            end else if (below_i) begin
              state       <= S_MOVE_DOWN;
              dir_up      <= 1'b0;
              moving_down <= 1'b1;
              move_cnt    <= '0;
            end
          end
          S_MOVE_UP: begin
            if (move_cnt == MOVE_LAST) begin
              move_cnt <= '0;
              floor    <= floor_up;
              if (!cont_up) begin
                state     <= S_IDLE;
                moving_up <= 1'b0;
              end
            end else begin
              move_cnt <= move_cnt + 1'b1;
            end
          end
          S_MOVE_DOWN: begin
            if (move_cnt == MOVE_LAST) begin
              move_cnt <= '0;
              floor    <= floor_dn;
              if (!cont_dn) begin
                state       <= S_IDLE;
                moving_down <= 1'b0;
              end
            end else begin
              move_cnt <= move_cnt + 1'b1;
            end
          end
          S_DOOR: begin
            if (call_req[floor]) begin
              door_cnt <= '0;
            end else if (door_cnt == DOOR_LAST) begin
              state     <= S_IDLE;
              door_open <= 1'b0;
              door_cnt  <= '0;
            end else begin
              door_cnt <= door_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
